food_placer: RTL and testbench
==============================

Name: food_placer

Overview:
- Consumes the LFSR coordinate stream (rand_x, rand_y) and places a food item on a free board cell.
- Each candidate is checked against the snake-occupancy responder through a req/ack query handshake. Occupied candidates are re-drawn.
- After MAX_TRIES failed random draws, the block falls back to a deterministic raster scan. It reports board_full if no free cell exists.
- Sits between the rng and the game controller; the controller pulses place_req after reset or after the snake eats.

Parameters:
- BOARD_WIDTH, 40, number of columns; legal x is 0..BOARD_WIDTH-1; must be ≤64.
- BOARD_HEIGHT, 30, number of rows; legal y is 0..BOARD_HEIGHT-1; must be ≤32.
- MAX_TRIES, 16, random draws before switching to the raster scan; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- place_req  in  1  one-cycle pulse requesting a new food position; ignored while busy=1.
- rand_x  in  6  random column from the rng.
- rand_y  in  5  random row from the rng.
- query_req  out  1  occupancy query valid; held high until query_ack.
- query_x  out  6  column being queried; stable while query_req=1.
- query_y  out  5  row being queried; stable while query_req=1.
- query_ack  in  1  responder completes the query; may be high in the same cycle query_req rises.
- query_hit  in  1  1 = cell occupied; sampled only in a cycle with query_req & query_ack.
- food_x  out  6  current food column.
- food_y  out  5  current food row.
- food_valid  out  1  food_x/food_y hold a placed, free cell.
- place_done  out  1  one-cycle pulse: placement attempt finished, either success or board_full.
- busy  out  1  placement in progress.
- board_full  out  1  last attempt found no free cell; sticky until the next accepted place_req.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0 immediately. State=IDLE; try counter and scan coordinates cleared. A reset mid-query drops query_req at once; the responder must tolerate an abandoned query.
- All outputs are registered.
- States: IDLE, SAMPLE, QUERY, SCAN, DONE.
- IDLE:
  - On place_req=1, next edge: busy=1, food_valid=0, board_full=0, tries=0, state→SAMPLE.
- SAMPLE (1 cycle):
  - Latch cand=(rand_x, rand_y).
  - If rand_x≥BOARD_WIDTH or rand_y≥BOARD_HEIGHT: count as a failed try (tries+1), no query issued, stay in SAMPLE. The switch to SCAN at tries=MAX_TRIES still applies.
  - Otherwise: query_req=1, query_x/y=cand, state→QUERY.
- QUERY: hold query_req, query_x and query_y constant until query_ack=1. On the ack edge, query_req→0 and:
  - hit=0: food_x/y←cand, state→DONE.
  - hit=1 and random mode: tries+1. If the new tries<MAX_TRIES, →SAMPLE; else →SCAN with scan=(0,0).
  - hit=1 and scan mode: advance scan, x first, wrap x at BOARD_WIDTH-1 and increment y. If the just-queried cell was (BOARD_WIDTH-1, BOARD_HEIGHT-1): board_full=1, →DONE.
- SCAN (1 cycle): query_req=1 with query_x/y=scan, →QUERY in scan mode.
- DONE (1 cycle):
  - place_done=1 and busy→0 on the next edge; state→IDLE.
  - food_valid=1 unless board_full=1.
- Latency: with a zero-wait responder (ack in the same cycle as query_req) and a free first draw:
  - place_req at edge N, SAMPLE at N+1, query at N+2, DONE at N+3.
  - place_done is high during the cycle after edge N+3.
- place_req while busy is dropped, not queued.
- food_x/y keep their previous value until a successful placement overwrites them. They are not changed on board_full.
- The rng advances every clock, so each SAMPLE visit sees a fresh value. No handshake toward the rng.

Test Plan:
- Reset, then place_req with rand=(5,7) and a responder returning hit=0 with zero wait → query_x/y=(5,7), place_done 3 cycles after the req edge, food=(5,7), food_valid=1, board_full=0.
- Responder returns hit=1 for (5,7) and hit=0 for (12,3) drawn next, with ack delayed 4 cycles each → two queries; query_x/y stable during each wait; food=(12,3).
- MAX_TRIES=4, all random draws occupied, scan cells (0,0) and (1,0) occupied, (2,0) free → 4 random queries, then scan queries (0,0), (1,0), (2,0); food=(2,0).
- Every cell occupied, with BOARD_WIDTH=4, BOARD_HEIGHT=2 → scan ends at (3,1); board_full=1, food_valid=0, place_done pulse, food_x/y unchanged.
- rand_x=45 ≥ BOARD_WIDTH=40 → no query_req for that draw; tries increments; the next legal draw is queried.
- Assert reset=0 mid-QUERY with query_req=1 → query_req, busy and food_valid are 0 in the same cycle without a clock edge; a place_req after release starts cleanly. Also pulse place_req while busy → ignored, only one place_done.

Source files
------------

// File: rtl/food_placer.sv
// food_placer
//
// Places a food item on a free board cell. Candidates come from the rng
// coordinate stream (rand_x, rand_y). Each candidate is checked against the
// snake-occupancy responder with a req/ack query. Occupied or off-board draws
// are retried. After MAX_TRIES failed random draws the block switches to a
// raster scan from (0,0). If the scan reaches the last cell without finding a
// free one, the block reports board_full.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   place_req   one-cycle request for a new food position (ignored while busy)
//   rand_x/y    random column/row from the rng
//   query_req   occupancy query valid, held until query_ack
//   query_x/y   cell being queried, stable while query_req=1
//   query_ack   responder completes the query (may coincide with query_req rise)
//   query_hit   1 = queried cell occupied, valid with query_req & query_ack
//   food_x/y    current food position
//   food_valid  food_x/y hold a placed, free cell
//   place_done  one-cycle pulse at the end of every placement attempt
//   busy        placement in progress
//   board_full  last attempt found no free cell (sticky until next request)
module food_placer #(
  parameter int BOARD_WIDTH  = 40,
  parameter int BOARD_HEIGHT = 30,
  parameter int MAX_TRIES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_req,
  input  logic [5:0] rand_x,
  input  logic [4:0] rand_y,
  output logic       query_req,
  output logic [5:0] query_x,
  output logic [4:0] query_y,
  input  logic       query_ack,
  input  logic       query_hit,
  output logic [5:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       place_done,
  output logic       busy,
  output logic       board_full
);

  // One extra bit on the limits so a full 64-column / 32-row board compares
  // correctly against the 6-bit / 5-bit coordinates.
  localparam logic [6:0] W_LIM   = 7'(BOARD_WIDTH);
  localparam logic [5:0] H_LIM   = 6'(BOARD_HEIGHT);
  localparam logic [5:0] X_LAST  = 6'(BOARD_WIDTH - 1);
  localparam logic [4:0] Y_LAST  = 5'(BOARD_HEIGHT - 1);
  localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_QUERY,
    S_SCAN,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] tries, tries_nxt;
  logic       scan_mode, scan_mode_nxt;
  logic [5:0] scan_x, scan_x_nxt;
  logic [4:0] scan_y, scan_y_nxt;

  logic       query_req_nxt;
  logic [5:0] query_x_nxt;
  logic [4:0] query_y_nxt;
  logic [5:0] food_x_nxt;
  logic [4:0] food_y_nxt;
  logic       food_valid_nxt;
  logic       place_done_nxt;
  logic       busy_nxt;
  logic       board_full_nxt;

  logic [7:0] tries_inc;
  logic       rand_legal;

  assign tries_inc  = tries + 8'd1;
  assign rand_legal = ({1'b0, rand_x} < W_LIM) && ({1'b0, rand_y} < H_LIM);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tries      <= '0;
      scan_mode  <= 1'b0;
      scan_x     <= '0;
      scan_y     <= '0;
      query_req  <= 1'b0;
      query_x    <= '0;
      query_y    <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      place_done <= 1'b0;
      busy       <= 1'b0;
      board_full <= 1'b0;
    end else begin
      state      <= state_nxt;
      tries      <= tries_nxt;
      scan_mode  <= scan_mode_nxt;
      scan_x     <= scan_x_nxt;
      scan_y     <= scan_y_nxt;
      query_req  <= query_req_nxt;
      query_x    <= query_x_nxt;
      query_y    <= query_y_nxt;
      food_x     <= food_x_nxt;
      food_y     <= food_y_nxt;
      food_valid <= food_valid_nxt;
      place_done <= place_done_nxt;
      busy       <= busy_nxt;
      board_full <= board_full_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    tries_nxt      = tries;
    scan_mode_nxt  = scan_mode;
    scan_x_nxt     = scan_x;
    scan_y_nxt     = scan_y;
    query_req_nxt  = query_req;
    query_x_nxt    = query_x;
    query_y_nxt    = query_y;
    food_x_nxt     = food_x;
    food_y_nxt     = food_y;
    food_valid_nxt = food_valid;
    place_done_nxt = 1'b0;
    busy_nxt       = busy;
    board_full_nxt = board_full;

    case (state)
      S_IDLE: begin
        if (place_req) begin
          busy_nxt       = 1'b1;
          food_valid_nxt = 1'b0;
          board_full_nxt = 1'b0;
          tries_nxt      = '0;
          scan_mode_nxt  = 1'b0;
          scan_x_nxt     = '0;
          scan_y_nxt     = '0;
          state_nxt      = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (rand_legal) begin
          query_req_nxt = 1'b1;
          query_x_nxt   = rand_x;
          query_y_nxt   = rand_y;
          state_nxt     = S_QUERY;
        end else begin
          // Off-board draw burns a try without touching the responder.
          tries_nxt = tries_inc;
          if (tries_inc >= TRY_LIM) begin
            scan_mode_nxt = 1'b1;
            scan_x_nxt    = '0;
            scan_y_nxt    = '0;
            state_nxt     = S_SCAN;
          end
        end
      end

      S_QUERY: begin
        if (query_ack) begin
          query_req_nxt = 1'b0;
          if (!query_hit) begin
            food_x_nxt = query_x;
            food_y_nxt = query_y;
            state_nxt  = S_DONE;
          end else if (!scan_mode) begin
            tries_nxt = tries_inc;
            if (tries_inc < TRY_LIM) begin
              state_nxt = S_SAMPLE;
            end else begin
              scan_mode_nxt = 1'b1;
              scan_x_nxt    = '0;
              scan_y_nxt    = '0;
              state_nxt     = S_SCAN;
            end
          end else begin
            // In scan mode query_x/y equals the scan position, so advance from it.
            if (query_x == X_LAST && query_y == Y_LAST) begin
              board_full_nxt = 1'b1;
              state_nxt      = S_DONE;
            end else if (query_x == X_LAST) begin
              scan_x_nxt = '0;
              scan_y_nxt = query_y + 5'd1;
              state_nxt  = S_SCAN;
            end else begin
              scan_x_nxt = query_x + 6'd1;
              state_nxt  = S_SCAN;
            end
          end
        end
      end

      S_SCAN: begin
        query_req_nxt = 1'b1;
        query_x_nxt   = scan_x;
        query_y_nxt   = scan_y;
        state_nxt     = S_QUERY;
      end

      S_DONE: begin
        place_done_nxt = 1'b1;
        busy_nxt       = 1'b0;
        food_valid_nxt = !board_full;
        state_nxt      = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_food_placer.sv
// Directed testbench for food_placer. Two instances share clk/reset:
//   dut_a: default 40x30 board, MAX_TRIES=16
//   dut_b: 4x2 board, MAX_TRIES=4 (scan fallback and full board)
// A small responder per instance answers queries from an occupancy map
// after a programmable number of wait cycles.
module tb_food_placer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- dut_a ----------------
  logic       place_req_a = 1'b0;
  logic [5:0] rx_a = '0;
  logic [4:0] ry_a = '0;
  logic       qreq_a, ack_a, hit_a, fv_a, pd_a, busy_a, bf_a;
  logic [5:0] qx_a, fx_a;
  logic [4:0] qy_a, fy_a;
  logic [63:0] occ_a [32];
  int delay_a = 0, cnt_a = 0, bad_a = 0, unstable_a = 0, done_a = 0;
  logic        hold_a = 1'b0;
  logic [10:0] held_a = '0;
  logic [10:0] log_a [$];

  assign hit_a = occ_a[qy_a][qx_a];
  assign ack_a = qreq_a && (cnt_a >= delay_a);

  food_placer dut_a (
    .clk(clk), .reset(reset), .place_req(place_req_a), .rand_x(rx_a), .rand_y(ry_a),
    .query_req(qreq_a), .query_x(qx_a), .query_y(qy_a), .query_ack(ack_a), .query_hit(hit_a),
    .food_x(fx_a), .food_y(fy_a), .food_valid(fv_a), .place_done(pd_a), .busy(busy_a),
    .board_full(bf_a)
  );

  always @(posedge clk) begin
    if (!qreq_a || ack_a) cnt_a <= 0; else cnt_a <= cnt_a + 1;
    if (qreq_a && ack_a) log_a.push_back({qx_a, qy_a});
    if (qreq_a && (qx_a >= 6'd40 || qy_a >= 5'd30)) bad_a <= bad_a + 1;
    if (hold_a && qreq_a && {qx_a, qy_a} !== held_a) unstable_a <= unstable_a + 1;
    hold_a <= qreq_a && !ack_a;
    held_a <= {qx_a, qy_a};
    if (pd_a) done_a <= done_a + 1;
  end

  // ---------------- dut_b ----------------
  logic       place_req_b = 1'b0;
  logic [5:0] rx_b = '0;
  logic [4:0] ry_b = '0;
  logic       qreq_b, ack_b, hit_b, fv_b, pd_b, busy_b, bf_b;
  logic [5:0] qx_b, fx_b;
  logic [4:0] qy_b, fy_b;
  logic [63:0] occ_b [32];
  int delay_b = 0, cnt_b = 0, bad_b = 0;
  logic [10:0] log_b [$];

  assign hit_b = occ_b[qy_b][qx_b];
  assign ack_b = qreq_b && (cnt_b >= delay_b);

  food_placer #(.BOARD_WIDTH(4), .BOARD_HEIGHT(2), .MAX_TRIES(4)) dut_b (
    .clk(clk), .reset(reset), .place_req(place_req_b), .rand_x(rx_b), .rand_y(ry_b),
    .query_req(qreq_b), .query_x(qx_b), .query_y(qy_b), .query_ack(ack_b), .query_hit(hit_b),
    .food_x(fx_b), .food_y(fy_b), .food_valid(fv_b), .place_done(pd_b), .busy(busy_b),
    .board_full(bf_b)
  );

  always @(posedge clk) begin
    if (!qreq_b || ack_b) cnt_b <= 0; else cnt_b <= cnt_b + 1;
    if (qreq_b && ack_b) log_b.push_back({qx_b, qy_b});
    if (qreq_b && (qx_b >= 6'd4 || qy_b >= 5'd2)) bad_b <= bad_b + 1;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin occ_a[i] = '0; occ_b[i] = '0; end
    #1;
    vectors++;
    if ({qreq_a, qx_a, qy_a, fx_a, fy_a, fv_a, pd_a, busy_a, bf_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a outputs=%h expected 0",
               {qreq_a, qx_a, qy_a, fx_a, fy_a, fv_a, pd_a, busy_a, bf_a});
    end
    vectors++;
    if ({qreq_b, qx_b, qy_b, fx_b, fy_b, fv_b, pd_b, busy_b, bf_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b outputs=%h expected 0",
               {qreq_b, qx_b, qy_b, fx_b, fy_b, fv_b, pd_b, busy_b, bf_b});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_free_first();
    delay_a = 0;
    log_a.delete();
    rx_a = 6'd5; ry_a = 5'd7;
    place_req_a = 1'b1;
    @(negedge clk);               // after edge N
    place_req_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1) begin miscompares++; $display("FAIL t1_busy got=%b exp=1", busy_a); end
    @(negedge clk);               // after edge N+1
    vectors++;
    if ({qreq_a, qx_a, qy_a} !== {1'b1, 6'd5, 5'd7}) begin
      miscompares++; $display("FAIL t1_query got=%b/%0d/%0d exp=1/5/7", qreq_a, qx_a, qy_a);
    end
    @(negedge clk);               // after edge N+2
    vectors++;
    if (pd_a !== 1'b0) begin miscompares++; $display("FAIL t1_done_early got=%b exp=0", pd_a); end
    @(negedge clk);               // after edge N+3
    vectors++;
    if (pd_a !== 1'b1) begin miscompares++; $display("FAIL t1_done got=%b exp=1", pd_a); end
    vectors++;
    if ({fx_a, fy_a} !== {6'd5, 5'd7}) begin
      miscompares++; $display("FAIL t1_food got=%0d,%0d exp=5,7", fx_a, fy_a);
    end
    vectors++;
    if ({fv_a, bf_a, busy_a} !== 3'b100) begin
      miscompares++; $display("FAIL t1_flags fv/bf/busy got=%b exp=100", {fv_a, bf_a, busy_a});
    end
    @(negedge clk);
    vectors++;
    if (pd_a !== 1'b0) begin miscompares++; $display("FAIL t1_done_pulse got=%b exp=0", pd_a); end
  endtask

  task automatic test_hit_redraw();
    int ustart;
    ustart = unstable_a;
    delay_a = 4;
    occ_a[7][5] = 1'b1;
    log_a.delete();
    rx_a = 6'd5; ry_a = 5'd7;
    place_req_a = 1'b1;
    @(negedge clk);
    place_req_a = 1'b0;
    for (int i = 0; i < 20 && qreq_a !== 1'b1; i++) @(negedge clk);
    rx_a = 6'd12; ry_a = 5'd3;
    for (int i = 0; i < 100 && pd_a !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (pd_a !== 1'b1) begin miscompares++; $display("FAIL t2_done got=%b exp=1", pd_a); end
    vectors++;
    if (log_a.size() !== 2) begin
      miscompares++; $display("FAIL t2_nquery got=%0d exp=2", log_a.size());
    end
    if (log_a.size() >= 2) begin
      vectors++;
      if (log_a[0] !== {6'd5, 5'd7}) begin
        miscompares++; $display("FAIL t2_q0 got=%h exp=%h", log_a[0], {6'd5, 5'd7});
      end
      vectors++;
      if (log_a[1] !== {6'd12, 5'd3}) begin
        miscompares++; $display("FAIL t2_q1 got=%h exp=%h", log_a[1], {6'd12, 5'd3});
      end
    end
    vectors++;
    if (unstable_a !== ustart) begin
      miscompares++; $display("FAIL t2_stable changes=%0d exp=0", unstable_a - ustart);
    end
    vectors++;
    if ({fx_a, fy_a, fv_a} !== {6'd12, 5'd3, 1'b1}) begin
      miscompares++; $display("FAIL t2_food got=%0d,%0d v=%b exp=12,3 v=1", fx_a, fy_a, fv_a);
    end
    occ_a[7][5] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal_draw();
    int bstart;
    bstart = bad_a;
    delay_a = 0;
    log_a.delete();
    rx_a = 6'd45; ry_a = 5'd2;
    place_req_a = 1'b1;
    @(negedge clk);               // after edge N: SAMPLE
    place_req_a = 1'b0;
    @(negedge clk);               // after edge N+1: 45 rejected
    vectors++;
    if (qreq_a !== 1'b0) begin miscompares++; $display("FAIL t5_noquery got=%b exp=0", qreq_a); end
    rx_a = 6'd9; ry_a = 5'd9;
    @(negedge clk);               // after edge N+2
    vectors++;
    if ({qreq_a, qx_a, qy_a} !== {1'b1, 6'd9, 5'd9}) begin
      miscompares++; $display("FAIL t5_query got=%b/%0d/%0d exp=1/9/9", qreq_a, qx_a, qy_a);
    end
    for (int i = 0; i < 20 && pd_a !== 1'b1; i++) @(negedge clk);
    vectors++;
    if ({pd_a, fx_a, fy_a} !== {1'b1, 6'd9, 5'd9}) begin
      miscompares++; $display("FAIL t5_food done=%b got=%0d,%0d exp=1 9,9", pd_a, fx_a, fy_a);
    end
    vectors++;
    if (log_a.size() !== 1 || bad_a !== bstart) begin
      miscompares++; $display("FAIL t5_queries n=%0d bad=%0d exp n=1 bad=0", log_a.size(), bad_a - bstart);
    end
    @(negedge clk);
  endtask

  task automatic test_scan_fallback();
    logic [10:0] expq [7];
    expq = '{{6'd3, 5'd1}, {6'd3, 5'd1}, {6'd3, 5'd1}, {6'd3, 5'd1},
             {6'd0, 5'd0}, {6'd1, 5'd0}, {6'd2, 5'd0}};
    delay_b = 1;
    occ_b[1][3] = 1'b1; occ_b[0][0] = 1'b1; occ_b[0][1] = 1'b1;
    log_b.delete();
    rx_b = 6'd3; ry_b = 5'd1;
    place_req_b = 1'b1;
    @(negedge clk);
    place_req_b = 1'b0;
    for (int i = 0; i < 200 && pd_b !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (pd_b !== 1'b1) begin miscompares++; $display("FAIL t3_done got=%b exp=1", pd_b); end
    vectors++;
    if (log_b.size() !== 7) begin miscompares++; $display("FAIL t3_nquery got=%0d exp=7", log_b.size()); end
    for (int i = 0; i < 7 && i < log_b.size(); i++) begin
      vectors++;
      if (log_b[i] !== expq[i]) begin
        miscompares++; $display("FAIL t3_q%0d got=%h exp=%h", i, log_b[i], expq[i]);
      end
    end
    vectors++;
    if ({fx_b, fy_b, fv_b, bf_b} !== {6'd2, 5'd0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL t3_food got=%0d,%0d v=%b full=%b exp=2,0 v=1 full=0", fx_b, fy_b, fv_b, bf_b);
    end
    @(negedge clk);
  endtask

  task automatic test_board_full();
    for (int i = 0; i < 32; i++) occ_b[i] = '1;
    delay_b = 0;
    log_b.delete();
    rx_b = 6'd3; ry_b = 5'd1;
    place_req_b = 1'b1;
    @(negedge clk);
    place_req_b = 1'b0;
    for (int i = 0; i < 200 && pd_b !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (pd_b !== 1'b1) begin miscompares++; $display("FAIL t4_done got=%b exp=1", pd_b); end
    vectors++;
    if ({bf_b, fv_b, busy_b} !== 3'b100) begin
      miscompares++; $display("FAIL t4_flags full/fv/busy got=%b exp=100", {bf_b, fv_b, busy_b});
    end
    vectors++;
    if ({fx_b, fy_b} !== {6'd2, 5'd0}) begin
      miscompares++; $display("FAIL t4_food_kept got=%0d,%0d exp=2,0", fx_b, fy_b);
    end
    vectors++;
    if (log_b.size() !== 12) begin miscompares++; $display("FAIL t4_nquery got=%0d exp=12", log_b.size()); end
    if (log_b.size() == 12) begin
      vectors++;
      if (log_b[4] !== {6'd0, 5'd0}) begin miscompares++; $display("FAIL t4_scan_first got=%h exp=000", log_b[4]); end
      vectors++;
      if (log_b[11] !== {6'd3, 5'd1}) begin
        miscompares++; $display("FAIL t4_scan_last got=%h exp=%h", log_b[11], {6'd3, 5'd1});
      end
    end
    @(negedge clk);
    vectors++;
    if ({pd_b, bf_b} !== 2'b01) begin
      miscompares++; $display("FAIL t4_sticky done/full got=%b exp=01", {pd_b, bf_b});
    end
  endtask

  task automatic test_illegal_tries();
    int bstart;
    bstart = bad_b;
    for (int i = 0; i < 32; i++) occ_b[i] = '0;
    log_b.delete();
    rx_b = 6'd5; ry_b = 5'd0;   // always off the 4-wide board
    place_req_b = 1'b1;
    @(negedge clk);
    place_req_b = 1'b0;
    vectors++;
    if ({busy_b, bf_b} !== 2'b10) begin
      miscompares++; $display("FAIL t5b_accept busy/full got=%b exp=10", {busy_b, bf_b});
    end
    for (int i = 0; i < 50 && pd_b !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (log_b.size() !== 1 || bad_b !== bstart) begin
      miscompares++; $display("FAIL t5b_queries n=%0d bad=%0d exp n=1 bad=0", log_b.size(), bad_b - bstart);
    end
    if (log_b.size() == 1) begin
      vectors++;
      if (log_b[0] !== {6'd0, 5'd0}) begin miscompares++; $display("FAIL t5b_scan got=%h exp=000", log_b[0]); end
    end
    vectors++;
    if ({pd_b, fx_b, fy_b, fv_b} !== {1'b1, 6'd0, 5'd0, 1'b1}) begin
      miscompares++; $display("FAIL t5b_food done=%b got=%0d,%0d v=%b exp=1 0,0 v=1", pd_b, fx_b, fy_b, fv_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_query();
    int dstart;
    delay_a = 4;
    rx_a = 6'd20; ry_a = 5'd10;
    place_req_a = 1'b1;
    @(negedge clk);
    place_req_a = 1'b0;
    for (int i = 0; i < 20 && qreq_a !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (qreq_a !== 1'b1) begin miscompares++; $display("FAIL t6_inquery got=%b exp=1", qreq_a); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({qreq_a, busy_a, fv_a} !== 3'b000) begin
      miscompares++; $display("FAIL t6_async qreq/busy/fv got=%b exp=000", {qreq_a, busy_a, fv_a});
    end
    vectors++;
    if ({fx_a, fy_a} !== '0) begin
      miscompares++; $display("FAIL t6_food_clr got=%0d,%0d exp=0,0", fx_a, fy_a);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    delay_a = 0;
    @(negedge clk);
    dstart = done_a;
    place_req_a = 1'b1;
    @(negedge clk);
    place_req_a = 1'b1;          // while busy: must be dropped
    @(negedge clk);
    place_req_a = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (done_a - dstart !== 1) begin
      miscompares++; $display("FAIL t6_one_done got=%0d exp=1", done_a - dstart);
    end
    vectors++;
    if ({fx_a, fy_a, fv_a, busy_a} !== {6'd20, 5'd10, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL t6_restart got=%0d,%0d v=%b busy=%b exp=20,10 v=1 busy=0", fx_a, fy_a, fv_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_free_first();
    test_hit_redraw();
    test_illegal_draw();
    test_scan_fallback();
    test_board_full();
    test_illegal_tries();
    test_reset_mid_query();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
